// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle: ID/EX hazard sources from the datapath, and the
// stall/flush/status outputs going back to it.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_WIDTH = 4,
  parameter int CNT_WIDTH = 16
);
  logic [REG_WIDTH-1:0] rsD;
  logic [REG_WIDTH-1:0] rtD;
  logic                 R_type;
  logic                 MemReadE;
  logic [REG_WIDTH-1:0] rtE;
  logic                 FloatingE;
  logic                 branch_taken_i;
  logic                 Jump;
  logic                 Stop;

  logic                 stall_PC_o;
  logic                 stall_IF_ID_o;
  logic                 flush_IF_ID_o;
  logic                 stall_ID_EX_o;
  logic                 flush_ID_EX_o;
  logic                 halted_o;
  logic [1:0]           state_o;
  logic [CNT_WIDTH-1:0] stall_cnt_o;

  modport master (
    output rsD, rtD, R_type, MemReadE, rtE, FloatingE, branch_taken_i, Jump, Stop,
    input  stall_PC_o, stall_IF_ID_o, flush_IF_ID_o, stall_ID_EX_o, flush_ID_EX_o,
           halted_o, state_o, stall_cnt_o
  );

  modport slave (
    input  rsD, rtD, R_type, MemReadE, rtE, FloatingE, branch_taken_i, Jump, Stop,
    output stall_PC_o, stall_IF_ID_o, flush_IF_ID_o, stall_ID_EX_o, flush_ID_EX_o,
           halted_o, state_o, stall_cnt_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: resolves branch, floating-op, load-use, stop and
// jump hazards into stall/flush controls, and counts PC stall cycles.
module pipeline_hazard_ctrl #(
  parameter int REG_WIDTH  = 4,
  parameter int FP_LATENCY = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] FPWAIT = 2'd1;
  localparam logic [1:0] HALT   = 2'd2;

  localparam logic [3:0]           FP_LOAD = 4'(FP_LATENCY - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           state, state_next;
  logic [3:0]           fp_cnt, fp_cnt_next;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [REG_WIDTH-1:0] rs_id, rt_id, rt_ex;
  logic                 load_use;
  logic                 stall_pc, stall_if_id, flush_if_id, stall_id_ex, flush_id_ex;

  assign rs_id    = hz.rsD;
  assign rt_id    = hz.rtD;
  assign rt_ex    = hz.rtE;
  assign load_use = hz.MemReadE & ((rt_ex == rs_id) | (hz.R_type & (rt_ex == rt_id)));

  // Only the highest-priority cause acts in RUN; FPWAIT ignores new causes
  // because the same floating instruction is still being held in EX.
  always_comb begin
    state_next  = state;
    fp_cnt_next = fp_cnt;
    stall_pc    = 1'b0;
    stall_if_id = 1'b0;
    flush_if_id = 1'b0;
    stall_id_ex = 1'b0;
    flush_id_ex = 1'b0;
    case (state)
      RUN: begin
        if (hz.branch_taken_i) begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (hz.FloatingE) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          stall_id_ex = 1'b1;
          fp_cnt_next = FP_LOAD;
          state_next  = FPWAIT;
        end else if (load_use) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (hz.Stop) begin
          flush_if_id = 1'b1;
          state_next  = HALT;
        end else if (hz.Jump) begin
          flush_if_id = 1'b1;
        end
      end
      FPWAIT: begin
        if (fp_cnt != 4'd1) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          stall_id_ex = 1'b1;
          fp_cnt_next = fp_cnt - 4'd1;
        end else begin
          fp_cnt_next = 4'd0;
          state_next  = RUN;
        end
      end
      HALT: begin
        stall_pc    = 1'b1;
        stall_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end
      default: begin
        state_next  = RUN;
        fp_cnt_next = 4'd0;
      end
    endcase
    if (rst) begin
      stall_pc    = 1'b0;
      stall_if_id = 1'b0;
      flush_if_id = 1'b0;
      stall_id_ex = 1'b0;
      flush_id_ex = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      fp_cnt    <= 4'd0;
      stall_cnt <= '0;
    end else begin
      state  <= state_next;
      fp_cnt <= fp_cnt_next;
      if (stall_pc && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  assign hz.stall_PC_o    = stall_pc;
  assign hz.stall_IF_ID_o = stall_if_id;
  assign hz.flush_IF_ID_o = flush_if_id;
  assign hz.stall_ID_EX_o = stall_id_ex;
  assign hz.flush_ID_EX_o = flush_id_ex & ~stall_id_ex;
  assign hz.halted_o      = (state == HALT);
  assign hz.state_o       = state;
  assign hz.stall_cnt_o   = stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, scoreboard-based bench for pipeline_hazard_ctrl; a narrow stall
// counter keeps the saturation case short.
module tb_pipeline_hazard_ctrl;

  localparam int REG_WIDTH  = 4;
  localparam int FP_LATENCY = 3;
  localparam int CNT_WIDTH  = 5;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // ctl bit order: stall_PC, stall_IF_ID, flush_IF_ID, stall_ID_EX, flush_ID_EX, halted
  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_LU   = 6'b110010;
  localparam logic [5:0] C_BR   = 6'b001010;
  localparam logic [5:0] C_FP   = 6'b110100;
  localparam logic [5:0] C_FLIF = 6'b001000;
  localparam logic [5:0] C_HALT = 6'b110011;

  typedef struct packed {
    logic [5:0]           ctl;
    logic [1:0]           st;
    logic [CNT_WIDTH-1:0] cnt;
  } exp_t;

  logic clk;
  logic rst;
  int   tests_run;
  int   fail_cnt;
  logic [CNT_WIDTH-1:0] exp_cnt;
  exp_t sb[$];

  pipeline_hazard_ctrl_if #(.REG_WIDTH(REG_WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

  pipeline_hazard_ctrl #(
    .REG_WIDTH (REG_WIDTH),
    .FP_LATENCY(FP_LATENCY),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.rsD            = '0;
    bus.rtD            = '0;
    bus.R_type         = 1'b0;
    bus.MemReadE       = 1'b0;
    bus.rtE            = '0;
    bus.FloatingE      = 1'b0;
    bus.branch_taken_i = 1'b0;
    bus.Jump           = 1'b0;
    bus.Stop           = 1'b0;
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [5:0] obs_ctl;
    tests_run++;
    assert (sb.size() != 0) else begin
      fail_cnt++;
      $error("[TB] FAIL scoreboard: observed empty queue, expected an entry");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      obs_ctl = {bus.stall_PC_o, bus.stall_IF_ID_o, bus.flush_IF_ID_o,
                 bus.stall_ID_EX_o, bus.flush_ID_EX_o, bus.halted_o};
      tests_run++;
      assert (obs_ctl === e.ctl) else begin
        fail_cnt++;
        $error("[TB] FAIL ctl @%0t: observed %b expected %b", $time, obs_ctl, e.ctl);
      end
      tests_run++;
      assert (bus.state_o === e.st) else begin
        fail_cnt++;
        $error("[TB] FAIL state @%0t: observed %0d expected %0d", $time, bus.state_o, e.st);
      end
      tests_run++;
      assert (bus.stall_cnt_o === e.cnt) else begin
        fail_cnt++;
        $error("[TB] FAIL stall_cnt @%0t: observed %0d expected %0d", $time, bus.stall_cnt_o, e.cnt);
      end
    end
  endtask

  // Called just after a falling edge with inputs already driven; leaves the
  // bench at the next falling edge.
  task automatic applyStimulus(input logic [5:0] ctl, input logic [1:0] st);
    exp_t e;
    e.ctl = ctl;
    e.st  = st;
    e.cnt = exp_cnt;
    sb.push_back(e);
    #1;
    checkOutput();
    @(posedge clk);
    if (ctl[5] && !rst && (exp_cnt != CNT_MAX))
      exp_cnt = exp_cnt + 1'b1;
    @(negedge clk);
  endtask

  initial begin
    tests_run = 0;
    fail_cnt  = 0;
    exp_cnt   = '0;
    rst       = 1'b1;
    clear_inputs();

    // reset: outputs quiet even with hazard inputs active
    @(negedge clk);
    bus.branch_taken_i = 1'b1;
    bus.MemReadE = 1'b1; bus.rtE = 4'd3; bus.rsD = 4'd3;
    applyStimulus(C_NONE, 2'd0);
    clear_inputs();
    rst = 1'b0;
    applyStimulus(C_NONE, 2'd0);

    // load-use on rs: one-cycle stall
    bus.MemReadE = 1'b1; bus.rtE = 4'd3; bus.rsD = 4'd3;
    applyStimulus(C_LU, 2'd0);
    clear_inputs();
    applyStimulus(C_NONE, 2'd0);

    // load-use on rt only matters for R-type
    bus.MemReadE = 1'b1; bus.rtE = 4'd5; bus.rtD = 4'd5; bus.rsD = 4'd1;
    applyStimulus(C_NONE, 2'd0);
    bus.R_type = 1'b1;
    applyStimulus(C_LU, 2'd0);
    clear_inputs();
    applyStimulus(C_NONE, 2'd0);

    // floating op held three cycles; other causes ignored in FPWAIT
    bus.FloatingE = 1'b1;
    applyStimulus(C_FP, 2'd0);
    bus.Stop = 1'b1; bus.MemReadE = 1'b1; bus.rtE = 4'd2; bus.rsD = 4'd2;
    applyStimulus(C_FP, 2'd1);
    bus.Stop = 1'b0; bus.Jump = 1'b1; bus.branch_taken_i = 1'b1;
    applyStimulus(C_NONE, 2'd1);
    clear_inputs();
    applyStimulus(C_NONE, 2'd0);

    // branch beats everything else
    bus.branch_taken_i = 1'b1; bus.Jump = 1'b1; bus.FloatingE = 1'b1; bus.Stop = 1'b1;
    bus.MemReadE = 1'b1; bus.rtE = 4'd7; bus.rsD = 4'd7;
    applyStimulus(C_BR, 2'd0);
    clear_inputs();
    applyStimulus(C_NONE, 2'd0);

    // jump alone, and load-use beats jump
    bus.Jump = 1'b1;
    applyStimulus(C_FLIF, 2'd0);
    bus.MemReadE = 1'b1; bus.rtE = 4'd9; bus.rsD = 4'd9;
    applyStimulus(C_LU, 2'd0);
    clear_inputs();
    applyStimulus(C_NONE, 2'd0);

    // reset mid-FPWAIT
    bus.FloatingE = 1'b1;
    applyStimulus(C_FP, 2'd0);
    bus.FloatingE = 1'b0;
    applyStimulus(C_FP, 2'd1);
    rst = 1'b1;
    exp_cnt = '0;
    bus.branch_taken_i = 1'b1;
    applyStimulus(C_NONE, 2'd0);
    clear_inputs();
    rst = 1'b0;
    applyStimulus(C_NONE, 2'd0);
    applyStimulus(C_NONE, 2'd0);

    // stop, halt, then reset out of halt
    bus.Stop = 1'b1;
    applyStimulus(C_FLIF, 2'd0);
    clear_inputs();
    applyStimulus(C_HALT, 2'd2);
    bus.branch_taken_i = 1'b1; bus.FloatingE = 1'b1;
    applyStimulus(C_HALT, 2'd2);
    clear_inputs();
    applyStimulus(C_HALT, 2'd2);
    rst = 1'b1;
    exp_cnt = '0;
    applyStimulus(C_NONE, 2'd0);
    rst = 1'b0;
    applyStimulus(C_NONE, 2'd0);

    // counter saturation: reach all-ones minus one, then stall three more
    bus.MemReadE = 1'b1; bus.rtE = 4'd4; bus.rsD = 4'd4;
    for (int i = 0; i < int'(CNT_MAX) - 1 + 3; i++)
      applyStimulus(C_LU, 2'd0);
    clear_inputs();
    applyStimulus(C_NONE, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
